// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Optional illegal-opcode check enabled by defining ALU_ARB_OPCHECK_EN.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic [OPW-1:0]   req1_op,
  input  logic [4:0]       req0_shf,
  input  logic [4:0]       req1_shf,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [OPW-1:0]   alu_op,
  output logic [4:0]       alu_shf,
  input  logic [WIDTH-1:0] alu_out,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_prio;
  logic             r_owner;
  logic [WIDTH-1:0] r_srca;
  logic [WIDTH-1:0] r_srcb;
  logic [OPW-1:0]   r_op;
  logic [4:0]       r_shf;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_busy;

  logic             w_winner;
  logic             w_grant;
  logic             w_rsp_done;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [OPW-1:0]   w_sel_op;
  logic [4:0]       w_sel_shf;

  // Contention goes to the prio requester; otherwise the lone valid one wins.
  assign w_winner   = (&req_valid) ? r_prio : req_valid[1];
  assign w_grant    = (r_state == ST_IDLE) && (|req_valid);
  assign w_rsp_done = (r_state == ST_RESP) && rsp_ready[r_owner];

  assign w_sel_a   = w_winner ? req1_a   : req0_a;
  assign w_sel_b   = w_winner ? req1_b   : req0_b;
  assign w_sel_op  = w_winner ? req1_op  : req0_op;
  assign w_sel_shf = w_winner ? req1_shf : req0_shf;

  // Gated by reset so every output reads 0 while reset is held.
  assign req_ready = (w_grant && !reset) ? (w_winner ? 2'b10 : 2'b01) : 2'b00;

  assign alu_srca  = r_srca;
  assign alu_srcb  = r_srcb;
  assign alu_op    = r_op;
  assign alu_shf   = r_shf;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;

`ifdef ALU_ARB_OPCHECK_EN
  logic r_illegal;
  logic r_rsp_err;

  assign rsp_err = r_rsp_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_illegal <= (w_sel_op > OPW'(2));
      end
      if (r_state == ST_EXEC) begin
        r_rsp_err <= r_illegal;
      end
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_prio      <= 1'b0;
      r_owner     <= 1'b0;
      r_srca      <= '0;
      r_srcb      <= '0;
      r_op        <= '0;
      r_shf       <= '0;
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_srca  <= w_sel_a;
            r_srcb  <= w_sel_b;
            r_op    <= w_sel_op;
            r_shf   <= w_sel_shf;
            r_owner <= w_winner;
            r_busy  <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
`ifdef ALU_ARB_OPCHECK_EN
          r_rsp_data <= r_illegal ? '0 : alu_out;
`else
          r_rsp_data <= alu_out;
`endif
          r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_done) begin
            r_rsp_valid <= 2'b00;
            r_busy      <= 1'b0;
            r_prio      <= ~r_owner;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
